// File: rtl/rr_arb_pkg.sv
// Shared types and widths for the round-robin priority arbiter.
package rr_arb_pkg;

  localparam int unsigned NREQ_C = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Rotate right by s: bit i of the result is v[(i + s) mod NREQ_C].
  function automatic logic [NREQ_C-1:0] rotr(input logic [NREQ_C-1:0] v,
                                             input logic [ID_W-1:0]   s);
    logic [NREQ_C-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NREQ_C; i++) begin
      logic [ID_W-1:0] k;
      k    = ID_W'(i) + s;
      r[i] = v[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// RR_PRIO_ARBITER_URGENT_EN adds the urgent override line.
interface rr_prio_arbiter_if;
  import rr_arb_pkg::*;

  logic [NREQ_C-1:0] req;
  logic [NREQ_C-1:0] gnt;
  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_id;
  logic [CNT_W-1:0]  hold_cnt;
`ifdef RR_PRIO_ARBITER_URGENT_EN
  logic              urgent;

  modport master (output req, urgent, input gnt, gnt_valid, gnt_id, hold_cnt);
  modport slave  (input req, urgent, output gnt, gnt_valid, gnt_id, hold_cnt);
`else
  modport master (output req, input gnt, gnt_valid, gnt_id, hold_cnt);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, hold_cnt);
`endif

endinterface

// File: rtl/rr_prio_arbiter_prio_enc4.sv
// 4-bit lowest-set-bit priority encoder; all-zero input encodes to 0.
module prio_enc4
  import rr_arb_pkg::*;
(
  input  logic [3:0]      in,
  output logic [ID_W-1:0] pos
);

  always_comb begin
    pos = '0;
    casez (in)
      4'b???1: pos = 2'd0;
      4'b??10: pos = 2'd1;
      4'b?100: pos = 2'd2;
      4'b1000: pos = 2'd3;
      default: pos = 2'd0;
    endcase
  end

endmodule

// File: rtl/rr_prio_arbiter.sv
// Round-robin arbiter for 4 requesters with bounded grant hold.
// Optional macro RR_PRIO_ARBITER_URGENT_EN: urgent line lets requester 0 win every arbitration.
module rr_prio_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               resetn,
  rr_prio_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic [ID_W-1:0]   id_q,    id_d;
  logic [ID_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic [NREQ-1:0]   rot;
  logic [ID_W-1:0]   enc;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   sel;
  logic              any;
  logic              keep;

  assign rot = rotr(bus.req, ptr_q);

  prio_enc4 u_enc (
    .in  (rot),
    .pos (enc)
  );

  assign win = enc + ptr_q;
  assign any = |bus.req;

`ifdef RR_PRIO_ARBITER_URGENT_EN
  assign sel = (bus.urgent && bus.req[0]) ? '0 : win;
`else
  assign sel = win;
`endif

  // Owner keeps the slot only while still requesting and under the hold limit;
  // every other BUSY case (release or expiry) falls through to re-arbitration.
  assign keep = (state_q == BUSY) && bus.req[id_q] && (cnt_q < HOLD_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (keep) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (any) begin
      state_d    = BUSY;
      gnt_d      = '0;
      gnt_d[sel] = 1'b1;
      id_d       = sel;
      cnt_d      = '0;
      ptr_d      = sel + ID_W'(1);
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      id_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.hold_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Directed bench: one arbiter with MAX_HOLD=8 (hold/handoff/reset) and one with MAX_HOLD=1 (rotation).
module tb_rr_prio_arbiter;
  import rr_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  rr_prio_arbiter_if ifh ();
  rr_prio_arbiter_if ifr ();

  rr_prio_arbiter #(.NREQ(4), .MAX_HOLD(8)) u_hold (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifh)
  );

  rr_prio_arbiter #(.NREQ(4), .MAX_HOLD(1)) u_rot (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_h(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic [7:0] c);
    chk({tag, ".gnt"},   32'(ifh.gnt),       32'(g));
    chk({tag, ".valid"}, 32'(ifh.gnt_valid), 32'(|g));
    chk({tag, ".id"},    32'(ifh.gnt_id),    32'(id));
    chk({tag, ".cnt"},   32'(ifh.hold_cnt),  32'(c));
  endtask

  task automatic chk_r(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, ".gnt"},   32'(ifr.gnt),       32'(g));
    chk({tag, ".valid"}, 32'(ifr.gnt_valid), 32'(|g));
    chk({tag, ".id"},    32'(ifr.gnt_id),    32'(id));
    chk({tag, ".cnt"},   32'(ifr.hold_cnt),  32'(0));
  endtask

  initial begin
    logic [3:0] rot_g [5];
    logic [1:0] rot_i [5];
    rot_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    resetn  = 1'b0;
    ifh.req = 4'b1111;
    ifr.req = 4'b0000;
`ifdef RR_PRIO_ARBITER_URGENT_EN
    ifh.urgent = 1'b0;
    ifr.urgent = 1'b0;
`endif
    step();
    step();
    chk_h("rst", 4'b0000, 2'd0, 8'd0);
    chk_r("rst_r", 4'b0000, 2'd0);

    resetn = 1'b1;
    step();
    chk_h("rst_rel", 4'b0001, 2'd0, 8'd0);

    // Owner 0 with competitor 2: exactly 8 cycles, then expiry hands to 2
    ifh.req = 4'b0101;
    for (int k = 1; k < 8; k++) begin
      step();
      chk_h($sformatf("hold0_%0d", k), 4'b0001, 2'd0, 8'(k));
    end
    step();
    chk_h("expire", 4'b0100, 2'd2, 8'd0);

    // Sole requester 2 is regranted with the counter cleared
    ifh.req = 4'b0100;
    for (int k = 1; k < 8; k++) begin
      step();
      chk_h($sformatf("hold2_%0d", k), 4'b0100, 2'd2, 8'(k));
    end
    step();
    chk_h("sole_regrant", 4'b0100, 2'd2, 8'd0);

    ifh.req = 4'b0110;
    step();
    chk_h("keep", 4'b0100, 2'd2, 8'd1);

    ifh.req = 4'b0010;
    step();
    chk_h("handoff", 4'b0010, 2'd1, 8'd0);

    ifh.req = 4'b1000;
    step();
    chk_h("handoff3", 4'b1000, 2'd3, 8'd0);

    ifh.req = 4'b0000;
    step();
    chk_h("idle", 4'b0000, 2'd0, 8'd0);

    ifh.req = 4'b0011;
    step();
    chk_h("wrap", 4'b0001, 2'd0, 8'd0);

    ifh.req = 4'b0010;
    step();
    chk_h("to1", 4'b0010, 2'd1, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_h($sformatf("hold1_%0d", k), 4'b0010, 2'd1, 8'(k));
    end

    resetn = 1'b0;
    step();
    chk_h("midrst", 4'b0000, 2'd0, 8'd0);

    // ptr cleared by reset: requester 1 wins, not 3
    resetn  = 1'b1;
    ifh.req = 4'b1010;
    step();
    chk_h("post_rst", 4'b0010, 2'd1, 8'd0);

    ifh.req = 4'b0100;
    step();
    chk_h("to2", 4'b0100, 2'd2, 8'd0);

    ifh.req = 4'b0000;
    step();
    chk_h("idle2", 4'b0000, 2'd0, 8'd0);

    // ptr is now 3: round-robin alone picks 3, urgent forces 0
    ifh.req = 4'b1001;
`ifdef RR_PRIO_ARBITER_URGENT_EN
    ifh.urgent = 1'b1;
    step();
    chk_h("urgent", 4'b0001, 2'd0, 8'd0);
    ifh.urgent = 1'b0;
`else
    step();
    chk_h("ptr3", 4'b1000, 2'd3, 8'd0);
`endif

    ifr.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_r($sformatf("rot_%0d", k), rot_g[k], rot_i[k]);
    end
    ifr.req = 4'b0000;
    step();
    chk_r("rot_idle", 4'b0000, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
